// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them from BASE_ADDR upward and holds the CPU until the image is in.
// Optional macro IMEM_LOADER_TERMINATOR_EN appends a zero word after the image.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic [15:0] word_count,
  output logic        overflow
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

`ifdef IMEM_LOADER_TERMINATOR_EN
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, TERM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE} state_t;
`endif

  state_t           state, state_next;
  logic [1:0]       byte_idx, byte_idx_next;
  logic [31:0]      asm_word, asm_next;
  logic [31:0]      merged;
  logic             mem_we_next, cpu_hold_next, done_next, overflow_next, in_ready_next;
  logic [31:0]      mem_addr_next, mem_wdata_next;
  logic [CNT_W-1:0] word_count_next;
  logic             wr_req;
  logic [31:0]      wr_data;

  // Place the incoming byte into its big-endian lane; lower lanes stay zero.
  always_comb begin
    merged = asm_word;
    case (byte_idx)
      2'd0:    merged = {in_byte, 24'h00_0000};
      2'd1:    merged = {asm_word[31:24], in_byte, 16'h0000};
      2'd2:    merged = {asm_word[31:16], in_byte, 8'h00};
      default: merged = {asm_word[31:8], in_byte};
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    asm_next        = asm_word;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    word_count_next = word_count;
    overflow_next   = overflow;
    done_next       = done;
    cpu_hold_next   = cpu_hold;
    in_ready_next   = 1'b0;
    wr_req          = 1'b0;
    wr_data         = 32'h0000_0000;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next      = LOAD;
          in_ready_next   = 1'b1;
          word_count_next = '0;
          overflow_next   = 1'b0;
          done_next       = 1'b0;
          cpu_hold_next   = 1'b1;
          byte_idx_next   = 2'd0;
          asm_next        = 32'h0000_0000;
        end
      end
      LOAD: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready) begin
          byte_idx_next = byte_idx + 2'd1;
          asm_next      = merged;
          if (byte_idx == 2'd3 || in_last) begin
            wr_req        = 1'b1;
            wr_data       = merged;
            asm_next      = 32'h0000_0000;
            byte_idx_next = 2'd0;
          end
          if (in_last) begin
            state_next    = FLUSH;
            in_ready_next = 1'b0;
          end
        end
      end
      FLUSH: begin
`ifdef IMEM_LOADER_TERMINATOR_EN
        state_next = TERM;
        wr_req     = 1'b1;
        wr_data    = 32'h0000_0000;
`else
        state_next    = DONE;
        done_next     = 1'b1;
        cpu_hold_next = 1'b0;
`endif
      end
`ifdef IMEM_LOADER_TERMINATOR_EN
      TERM: begin
        state_next    = DONE;
        done_next     = 1'b1;
        cpu_hold_next = 1'b0;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Completed words beyond capacity are dropped and flagged.
    if (wr_req) begin
      if (word_count == DEPTH_CNT) begin
        overflow_next = 1'b1;
      end else begin
        mem_we_next     = 1'b1;
        mem_addr_next   = BASE_ADDR + (32'(word_count) << 2);
        mem_wdata_next  = wr_data;
        word_count_next = word_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      asm_word   <= 32'h0000_0000;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'h0000_0000;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      asm_word   <= asm_next;
      in_ready   <= in_ready_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      cpu_hold   <= cpu_hold_next;
      done       <= done_next;
      word_count <= word_count_next;
      overflow   <= overflow_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance and a 2-word instance
// share stimulus; write strobes are logged and compared against hand-computed words.
module tb_imem_loader;

`ifdef IMEM_LOADER_TERMINATOR_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, cpu_hold, done, overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;

  logic        s_in_ready, s_mem_we, s_cpu_hold, s_done, s_overflow;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [15:0] s_word_count;

  imem_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .word_count(word_count),
    .overflow(overflow)
  );

  imem_loader #(.DEPTH_WORDS(2)) u_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_ready(s_in_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .cpu_hold(s_cpu_hold), .done(s_done), .word_count(s_word_count),
    .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];
  int          st_cyc[$];
  int          small_strobes = 0;
  int          stalls = 0;
  int          tests = 0;
  int          fails = 0;

  // Strobe logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      st_addr.push_back(mem_addr);
      st_data.push_back(mem_wdata);
      st_cyc.push_back(cyc);
    end
    if (s_mem_we) small_strobes <= small_strobes + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    st_addr.delete();
    st_data.delete();
    st_cyc.delete();
    small_strobes = 0;
    stalls = 0;
  endtask

  // All stimulus tasks begin and end on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 20) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard == 20) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic end_stream();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_strobe(input string tag, input int idx, input logic [31:0] addr,
                              input logic [31:0] data);
    if (idx < st_addr.size()) begin
      check({tag, "_addr"}, st_addr[idx], addr);
      check({tag, "_data"}, st_data[idx], data);
    end else begin
      check({tag, "_missing"}, 32'(st_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0040_0000);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0000_0000);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Single word with last on the fourth byte.
    clear_log();
    pulse_start();
    check("load_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b1);
    end_stream();
    check("t1_strobes", 32'(st_addr.size()), 32'(1 + TERM));
    check_strobe("t1_w0", 0, 32'h0040_0000, 32'h0810_0004);
`ifdef IMEM_LOADER_TERMINATOR_EN
    check_strobe("t1_term", 1, 32'h0040_0004, 32'h0000_0000);
`endif
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_word_count", 32'(word_count), 32'(1 + TERM));
    check("t1_mem_we_done", 32'(mem_we), 32'd0);

    // Twelve back-to-back bytes; small instance overflows after two words.
    clear_log();
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    for (int i = 1; i <= 12; i++) send_byte(8'(i), i == 12);
    end_stream();
    check("t2_strobes", 32'(st_addr.size()), 32'(3 + TERM));
    check_strobe("t2_w0", 0, 32'h0040_0000, 32'h0102_0304);
    check_strobe("t2_w1", 1, 32'h0040_0004, 32'h0506_0708);
    check_strobe("t2_w2", 2, 32'h0040_0008, 32'h090A_0B0C);
    if (st_cyc.size() >= 3) begin
      check("t2_gap01", 32'(st_cyc[1] - st_cyc[0]), 32'd4);
      check("t2_gap12", 32'(st_cyc[2] - st_cyc[1]), 32'd4);
    end else begin
      check("t2_gap_missing", 32'(st_cyc.size()), 32'd3);
    end
    check("t2_stalls", 32'(stalls), 32'd0);
    check("t2_word_count", 32'(word_count), 32'(3 + TERM));
    check("t2_overflow", 32'(overflow), 32'd0);
    check("t2_small_strobes", 32'(small_strobes), 32'd2);
    check("t2_small_overflow", 32'(s_overflow), 32'd1);
    check("t2_small_done", 32'(s_done), 32'd1);
    check("t2_small_word_count", 32'(s_word_count), 32'd2);

    // Partial final word is zero padded.
    clear_log();
    pulse_start();
    check("t3_overflow_cleared", 32'(s_overflow), 32'd0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    end_stream();
    check("t3_strobes", 32'(st_addr.size()), 32'(2 + TERM));
    check_strobe("t3_w0", 0, 32'h0040_0000, 32'hAABB_CCDD);
    check_strobe("t3_w1", 1, 32'h0040_0004, 32'h1122_0000);
    check("t3_word_count", 32'(word_count), 32'(2 + TERM));
    check("t3_done", 32'(done), 32'd1);

    // Reset mid-word aborts without a strobe, then a fresh load works.
    clear_log();
    pulse_start();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("t4_reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_no_strobe", 32'(st_addr.size()), 32'd0);
    pulse_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    end_stream();
    check("t4_strobes", 32'(st_addr.size()), 32'(1 + TERM));
    check_strobe("t4_w0", 0, 32'h0040_0000, 32'hDEAD_BEEF);
    check("t4_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream from a host/bench and assembles big-endian 32-bit words.
- Writes the words into instruction memory from BASE_ADDR upward.
- Holds the processor's PC/fetch path in hold until the image is complete, then releases it.
- Sits between the bench/boot source and the instruction memory write port.

Parameters:
- BASE_ADDR, 32'h00400000, byte address of first word written (must be word aligned).
- DEPTH_WORDS, 1024, capacity of instruction memory in words; writes beyond are dropped.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new load (sampled only in IDLE or DONE)
- in_valid  in  1  byte on in_byte is valid
- in_byte  in  8  stream byte
- in_last  in  1  qualifies final byte of image (with in_valid && in_ready)
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  32  byte address of word being written
- mem_wdata  out  32  word being written
- cpu_hold  out  1  high = processor must not advance PC
- done  out  1  image fully written
- word_count  out  16  words written by the current load
- overflow  out  1  sticky: at least one word dropped for exceeding DEPTH_WORDS

Behaviour:
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, word_count=0, overflow=0, byte index=0.
- Reset mid-load aborts immediately; partial word discarded; no strobe is issued.
- States:
  - IDLE: in_ready=0, cpu_hold=1. start -> LOAD.
  - LOAD: in_ready=1. Byte accepted when in_valid && in_ready.
    - Byte index 0..3: byte 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
    - Accepting byte 3 loads the assembled word into mem_wdata and pulses mem_we the next cycle, with mem_addr = BASE_ADDR + 4*word_count. word_count increments in the same cycle as the strobe.
    - Byte acceptance continues during the strobe cycle; there are no bubbles, so one word per 4 accepted bytes is sustained.
    - in_last on byte index 3: word written normally -> FLUSH.
    - in_last on byte index 0..2: unfilled low bytes padded with 8'h00; word strobed the next cycle -> FLUSH.
  - FLUSH: in_ready=0. Waits one cycle for the final strobe to retire, then -> DONE, or -> TERM when TERMINATOR_EN is defined.
  - DONE: done=1, cpu_hold=0, in_ready=0. Outputs hold until start or reset.
    - start in DONE -> LOAD: clears word_count, overflow and done; sets cpu_hold=1 on the next edge.
- Overflow: when word_count == DEPTH_WORDS, a completed word gets no mem_we, overflow is set (sticky) and word_count saturates. The stream is still consumed until in_last.
- in_last with in_valid but no accepted byte is ignored.
- start outside IDLE/DONE is ignored.
- Address arithmetic: 32-bit unsigned, no wrap check beyond DEPTH_WORDS.
- mem_we is never high in IDLE or DONE.

Optional Feature:
- Macro: IMEM_LOADER_TERMINATOR_EN.
- When defined:
  - FLUSH -> TERM. TERM issues one extra mem_we with mem_wdata=32'h00000000 at BASE_ADDR + 4*word_count, then -> DONE.
  - word_count includes the terminator. The processor bench halts fetch on a zero instruction, so the terminator acts as the image end marker.
  - If word_count == DEPTH_WORDS, the terminator is dropped and overflow is set.
- When undefined: no TERM state; FLUSH -> DONE directly.

Test Plan:
- Reset, start, bytes 08,10,00,04 with last on 04 -> one mem_we at mem_addr=32'h00400000, mem_wdata=32'h08100004. Then done=1, cpu_hold=0, word_count=1.
- 12 back-to-back bytes, in_valid held high, last on byte 12 -> strobes at 00400000/00400004/00400008 spaced exactly 4 cycles apart; in_ready never drops before FLUSH.
- 6 bytes AA,BB,CC,DD,11,22 with last on 22 -> words 32'hAABBCCDD and 32'h11220000; word_count=2.
- DEPTH_WORDS=2, 12 bytes -> only 2 strobes, overflow=1, done=1, word_count=2.
- Reset asserted after 2 bytes of a word -> no strobe, all outputs at reset values. Then start plus 4 bytes writes at 32'h00400000.
- TERMINATOR_EN defined, 4 bytes then last -> strobes at 00400000 (data) and 00400004 (32'h00000000); word_count=2.
